analog_input_integrator: RTL
============================

ANALOG_INPUT_INTEGRATOR -- requirements
Module: analog_input_integrator

Interface
REQ-001 The module SHALL have parameter NCH, default 2, giving the number of independent channels.
REQ-002 The module SHALL have parameter W, default 8, giving the value width per channel.
REQ-003 The module SHALL have parameter STEP_MIN, default 1, giving the first step size of a press.
REQ-004 The module SHALL have parameter STEP_MAX, default 8, giving the step size ceiling.
REQ-005 The module SHALL have parameter ACCEL_TICKS, default 4, giving the ticks between step increments.
REQ-006 The module SHALL have parameter RETURN_STEP, default 4, giving the spring-return step size.
REQ-007 The module SHALL have parameter DEADZONE, default 4, giving the analog deadzone (used only with ANALOG_IN_EN).
REQ-008 The module SHALL have port clk_sys, input, width 1: the single clock.
REQ-009 The module SHALL have port reset_n, input, width 1: synchronous, active-low reset.
REQ-010 The module SHALL have port tick_in, input, width 1: frame tick level (vsync); its rising edge triggers an update.
REQ-011 The module SHALL have ports plus and minus, input, width NCH each: the per-channel increase/decrease buttons.
REQ-012 The module SHALL have port mode, input, width NCH: 0 = hold on release, 1 = spring back to rest.
REQ-013 The module SHALL have ports rest_val, lo_val and hi_val, input, width NCH*W each, packed unsigned, channel 0 in the LSBs.
REQ-014 The module SHALL have port value, output, width NCH*W: the per-channel integrated value.
REQ-015 The module SHALL have port moving, output, width NCH: high while a channel is in any state other than IDLE.
REQ-016 The module SHALL have port upd, output, width 1: a one-cycle pulse in the cycle value is updated.

Function
REQ-017 tick_in SHALL be registered and its rising edge SHALL produce an internal one-cycle tick; value and upd SHALL update on the clock edge after that tick (2 cycles after tick_in is sampled high).
REQ-018 Each channel SHALL have states IDLE, INC, DEC and RETURN.
REQ-019 On a tick, the next state SHALL be INC if plus&~minus, DEC if minus&~plus; otherwise RETURN if mode=1 and value!=rest, else IDLE.
REQ-020 plus and minus pressed together SHALL be treated as neither pressed.
REQ-021 On entry to INC or DEC, including a direct reversal, step SHALL load STEP_MIN and the accel counter SHALL clear.
REQ-022 After each ACCEL_TICKS consecutive ticks in the same direction, step SHALL increase by 1, saturating at STEP_MAX.
REQ-023 INC/DEC arithmetic SHALL be done in W+1 bits and the result clamped to [lo_val, hi_val], with no wrap-around.
REQ-024 In RETURN, value SHALL move toward rest_val by RETURN_STEP without overshooting; when it reaches rest_val the channel SHALL go to IDLE.
REQ-025 In IDLE, and in hold mode after release, value SHALL remain unchanged.
REQ-026 Between ticks, value SHALL remain constant.
REQ-027 upd SHALL pulse on every tick, whether or not any value changed.

Reset
REQ-028 While reset_n=0 at a clock edge, every channel SHALL be set to value=rest_val clamped to [lo_val, hi_val], state=IDLE, step=STEP_MIN, accel counter=0; moving=0, upd=0, and the tick edge register=0.
REQ-029 Reset SHALL take priority over a simultaneous tick; a press in progress SHALL be abandoned.

Configuration
REQ-030 When ANALOG_IN_EN is defined, the ports ana_valid (input, NCH) and ana_in (input, NCH*W, signed per channel) SHALL exist.
REQ-031 With ANALOG_IN_EN defined, on a tick where ana_valid=1 and |ana_in|>DEADZONE, value SHALL become rest_val+ana_in clamped to [lo_val, hi_val], the channel state SHALL be forced to IDLE, and the buttons SHALL be ignored.
REQ-032 Without ANALOG_IN_EN, the ana_valid and ana_in ports SHALL be absent and the behaviour SHALL be buttons only.

Structure
REQ-033 The package analog_ctrl_pkg SHALL hold the state enum, the default parameter constants, and a saturating clamp function.
REQ-034 The per-channel logic SHALL be a sub-module analog_ctrl_chan, instantiated NCH times in a generate loop; the top level SHALL own only tick edge detection and upd.

Verification
(All scenarios use W=8, lo=0, hi=255, rest=128 unless stated.)
REQ-035 Mode 0, plus held for 12 ticks -> steps 1×4, 2×4, 3×4; value=152; release -> stays at 152, moving=0.
REQ-036 rest=250, plus held for 10 ticks -> value reaches 255 and holds there, never wraps to 0–7.
REQ-037 Mode 1, value=140, release -> 136, 132, 128 on successive ticks, then IDLE with moving=0.
REQ-038 plus and minus held together for 5 ticks -> value unchanged; plus held 6 ticks then switched to minus -> first DEC step=1.
REQ-039 reset_n=0 during INC at value 170 -> value=128, upd=0 on the next edge; tick_in asserted in the same cycle is ignored.
REQ-040 With ANALOG_IN_EN: ana_in=-20 -> value=108 at the next tick; ana_in=3 -> buttons control the channel.

Source files
------------

// File: rtl/analog_ctrl_pkg.sv
// Shared types, default parameters and clamp helper for the analog input integrator.
package analog_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INC    = 2'd1,
    ST_DEC    = 2'd2,
    ST_RETURN = 2'd3
  } chan_state_e;

  localparam int DEF_NCH         = 2;
  localparam int DEF_W           = 8;
  localparam int DEF_STEP_MIN    = 1;
  localparam int DEF_STEP_MAX    = 8;
  localparam int DEF_ACCEL_TICKS = 4;
  localparam int DEF_RETURN_STEP = 4;
  localparam int DEF_DEADZONE    = 4;

  function automatic int clamp_int(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/analog_ctrl_chan.sv
// One integrator channel: button-driven ramp with acceleration, hold or spring-return.
// Optional analog override is compiled in when ANALOG_IN_EN is defined.
module analog_ctrl_chan
  import analog_ctrl_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int STEP_MIN    = DEF_STEP_MIN,
  parameter int STEP_MAX    = DEF_STEP_MAX,
  parameter int ACCEL_TICKS = DEF_ACCEL_TICKS,
  parameter int RETURN_STEP = DEF_RETURN_STEP,
  parameter int DEADZONE    = DEF_DEADZONE
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  input  logic         tick,
  input  logic         plus,
  input  logic         minus,
  input  logic         mode,
  input  logic [W-1:0] rest_val,
  input  logic [W-1:0] lo_val,
  input  logic [W-1:0] hi_val,
`ifdef ANALOG_IN_EN
  input  logic         ana_valid,
  input  logic [W-1:0] ana_in,
`endif
  output logic [W-1:0] value,
  output logic         moving
);

  localparam int SW = $clog2(STEP_MAX + 1);
  localparam int AW = $clog2(ACCEL_TICKS + 1);

  chan_state_e   state_q, state_d;
  logic [W-1:0]  value_q, value_d;
  logic [SW-1:0] step_q, step_d;
  logic [AW-1:0] acc_q, acc_d;

  int   lo_i, hi_i, rest_i, cur_i, cur_step, acc_next, tgt, ana_tgt;
  logic btn_up, btn_dn, entering, ana_hit;

  // All arithmetic is in int so sums and differences never wrap before the clamp.
  always_comb begin
    lo_i     = int'(lo_val);
    hi_i     = int'(hi_val);
    rest_i   = clamp_int(int'(rest_val), lo_i, hi_i);
    cur_i    = int'(value_q);
    btn_up   = plus & ~minus;
    btn_dn   = minus & ~plus;
    entering = (btn_up && state_q != ST_INC) || (btn_dn && state_q != ST_DEC);
    cur_step = entering ? STEP_MIN : int'(step_q);
    acc_next = entering ? 1 : int'(acc_q) + 1;
    tgt      = cur_i;
    ana_hit  = 1'b0;
    ana_tgt  = rest_i;
`ifdef ANALOG_IN_EN
    ana_hit  = ana_valid && (int'($signed(ana_in)) > DEADZONE || int'($signed(ana_in)) < -DEADZONE);
    ana_tgt  = clamp_int(rest_i + int'($signed(ana_in)), lo_i, hi_i);
`endif
    state_d  = state_q;
    value_d  = value_q;
    step_d   = step_q;
    acc_d    = acc_q;

    if (tick) begin
      if (ana_hit) begin
        value_d = W'(ana_tgt);
        state_d = ST_IDLE;
        step_d  = SW'(STEP_MIN);
        acc_d   = '0;
      end else if (btn_up || btn_dn) begin
        tgt     = clamp_int(btn_up ? cur_i + cur_step : cur_i - cur_step, lo_i, hi_i);
        value_d = W'(tgt);
        state_d = btn_up ? ST_INC : ST_DEC;
        if (acc_next >= ACCEL_TICKS) begin
          acc_d  = '0;
          step_d = SW'((cur_step + 1 > STEP_MAX) ? STEP_MAX : cur_step + 1);
        end else begin
          acc_d  = AW'(acc_next);
          step_d = SW'(cur_step);
        end
      end else begin
        step_d = SW'(STEP_MIN);
        acc_d  = '0;
        if (mode && cur_i != rest_i) begin
          if (cur_i > rest_i)
            tgt = (cur_i - rest_i > RETURN_STEP) ? cur_i - RETURN_STEP : rest_i;
          else
            tgt = (rest_i - cur_i > RETURN_STEP) ? cur_i + RETURN_STEP : rest_i;
          value_d = W'(tgt);
          state_d = (tgt == rest_i) ? ST_IDLE : ST_RETURN;
        end else begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      value_q <= W'(rest_i);
      step_q  <= SW'(STEP_MIN);
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
    end
  end

  assign value  = value_q;
  assign moving = (state_q != ST_IDLE);

endmodule

// File: rtl/analog_input_integrator.sv
// Multi-channel analog control integrator: frame-tick edge detect, update strobe, per-channel ramps.
// Define ANALOG_IN_EN to add the ana_valid/ana_in analog override ports.
module analog_input_integrator
  import analog_ctrl_pkg::*;
#(
  parameter int NCH         = DEF_NCH,
  parameter int W           = DEF_W,
  parameter int STEP_MIN    = DEF_STEP_MIN,
  parameter int STEP_MAX    = DEF_STEP_MAX,
  parameter int ACCEL_TICKS = DEF_ACCEL_TICKS,
  parameter int RETURN_STEP = DEF_RETURN_STEP,
  parameter int DEADZONE    = DEF_DEADZONE
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             tick_in,
  input  logic [NCH-1:0]   plus,
  input  logic [NCH-1:0]   minus,
  input  logic [NCH-1:0]   mode,
  input  logic [NCH*W-1:0] rest_val,
  input  logic [NCH*W-1:0] lo_val,
  input  logic [NCH*W-1:0] hi_val,
`ifdef ANALOG_IN_EN
  input  logic [NCH-1:0]   ana_valid,
  input  logic [NCH*W-1:0] ana_in,
`endif
  output logic [NCH*W-1:0] value,
  output logic [NCH-1:0]   moving,
  output logic             upd
);

  logic tick_in_q, tick_in_d;
  logic tick_dly_q, tick_dly_d;
  logic tick_q, tick_d;
  logic upd_q, upd_d;

  // tick_q is high for exactly one cycle per rising edge of the registered vsync level.
  always_comb begin
    tick_in_d  = tick_in;
    tick_dly_d = tick_in_q;
    tick_d     = tick_in_q & ~tick_dly_q;
    upd_d      = tick_q;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      tick_in_q  <= 1'b0;
      tick_dly_q <= 1'b0;
      tick_q     <= 1'b0;
      upd_q      <= 1'b0;
    end else begin
      tick_in_q  <= tick_in_d;
      tick_dly_q <= tick_dly_d;
      tick_q     <= tick_d;
      upd_q      <= upd_d;
    end
  end

  assign upd = upd_q;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    analog_ctrl_chan #(
      .W          (W),
      .STEP_MIN   (STEP_MIN),
      .STEP_MAX   (STEP_MAX),
      .ACCEL_TICKS(ACCEL_TICKS),
      .RETURN_STEP(RETURN_STEP),
      .DEADZONE   (DEADZONE)
    ) u_chan (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .tick     (tick_q),
      .plus     (plus[gi]),
      .minus    (minus[gi]),
      .mode     (mode[gi]),
      .rest_val (rest_val[gi*W +: W]),
      .lo_val   (lo_val[gi*W +: W]),
      .hi_val   (hi_val[gi*W +: W]),
`ifdef ANALOG_IN_EN
      .ana_valid(ana_valid[gi]),
      .ana_in   (ana_in[gi*W +: W]),
`endif
      .value    (value[gi*W +: W]),
      .moving   (moving[gi])
    );
  end

endmodule
